// File: rtl/peripheral_bfm_master_generic_axi4_if.sv
// Bundle of the command, stream, completion and AXI4 channel signals around the master BFM.
// The master modport is the BFM's view; the slave modport is the testbench/slave side.
interface peripheral_bfm_master_generic_axi4_if;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id, cmd_len;
    logic [31:0] cmd_addr;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        done, done_timeout;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awadr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wrdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        input  wd_valid, wd_data, wd_strb, rd_ready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid,
        output cmd_ready, wd_ready, rd_valid, rd_data, rd_resp, rd_last,
        output done, done_resp, done_timeout,
        output awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wrdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        output wd_valid, wd_data, wd_strb, rd_ready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid,
        input  cmd_ready, wd_ready, rd_valid, rd_data, rd_resp, rd_last,
        input  done, done_resp, done_timeout,
        input  awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wrdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
    );
endinterface

// File: rtl/peripheral_bfm_master_generic_axi4.sv
// Command-driven AXI4 master BFM: one INCR burst of 32-bit beats in flight at a time,
// write/read data streamed through, registered completion pulse with worst response.
module peripheral_bfm_master_generic_axi4 #(
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [3:0]  AXI_CACHE = 4'b0000,
    parameter logic [2:0]  AXI_PROT  = 3'b000
) (
    input logic aclk,
    input logic areset,
    peripheral_bfm_master_generic_axi4_if.master bus
);
    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_e;

    state_e      state_q;
    logic [3:0]  id_q, len_q, beat_q;
    logic [31:0] addr_q, tcnt_q;
    logic [1:0]  acc_q, done_resp_q;
    logic        done_q, done_to_q, rdy_en_q;
    logic        hs, expired, is_last;
    logic [1:0]  rmax;
    logic        unused_ids;

    // Handshake of whichever channel the current state is waiting on
    always_comb begin
        hs = 1'b0;
        unique case (state_q)
            WADDR:   hs = bus.awready;
            WDATA:   hs = bus.wd_valid & bus.wready;
            WRESP:   hs = bus.bvalid;
            RADDR:   hs = bus.arready;
            RDATA:   hs = bus.rvalid & bus.rd_ready;
            default: hs = 1'b0;
        endcase
    end

    assign expired = (state_q != IDLE) && !hs && (tcnt_q == TIMEOUT - 1);
    assign is_last = (beat_q == len_q);
    assign rmax    = (bus.rresp > acc_q) ? bus.rresp : acc_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            tcnt_q      <= '0;
            acc_q       <= '0;
            done_resp_q <= '0;
            done_q      <= 1'b0;
            done_to_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            done_q   <= 1'b0;
            if (state_q != IDLE) begin
                tcnt_q <= hs ? '0 : tcnt_q + 32'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && rdy_en_q) begin
                        id_q    <= bus.cmd_id;
                        addr_q  <= bus.cmd_addr;
                        len_q   <= bus.cmd_len;
                        beat_q  <= '0;
                        acc_q   <= '0;
                        tcnt_q  <= '0;
                        state_q <= bus.cmd_write ? WADDR : RADDR;
                    end
                end
                WADDR: if (hs) state_q <= WDATA;
                WDATA: begin
                    if (hs) begin
                        beat_q <= beat_q + 4'd1;
                        if (is_last) state_q <= WRESP;
                    end
                end
                WRESP: begin
                    if (hs) begin
                        done_q      <= 1'b1;
                        done_resp_q <= bus.bresp;
                        done_to_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                RADDR: if (hs) state_q <= RDATA;
                RDATA: begin
                    if (hs) begin
                        acc_q  <= rmax;
                        beat_q <= beat_q + 4'd1;
                        // The slave may end the burst early with rlast; either terminator completes it
                        if (is_last || bus.rlast) begin
                            done_q      <= 1'b1;
                            done_resp_q <= rmax;
                            done_to_q   <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (expired) begin
                done_q      <= 1'b1;
                done_to_q   <= 1'b1;
                done_resp_q <= 2'b10;
                state_q     <= IDLE;
            end
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE) && rdy_en_q;
    assign bus.done         = done_q;
    assign bus.done_resp    = done_resp_q;
    assign bus.done_timeout = done_to_q;

    assign bus.awid    = id_q;
    assign bus.awadr   = addr_q;
    assign bus.awlen   = len_q;
    assign bus.awsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = AXI_CACHE;
    assign bus.awprot  = AXI_PROT;
    assign bus.awvalid = (state_q == WADDR);

    assign bus.wid      = id_q;
    assign bus.wvalid   = (state_q == WDATA) && bus.wd_valid;
    assign bus.wd_ready = (state_q == WDATA) && bus.wready;
    assign bus.wrdata   = (state_q == WDATA) ? bus.wd_data : '0;
    assign bus.wstrb    = (state_q == WDATA) ? bus.wd_strb : '0;
    assign bus.wlast    = (state_q == WDATA) && is_last;
    assign bus.bready   = (state_q == WDATA) || (state_q == WRESP);

    assign bus.arid    = id_q;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len_q;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = AXI_CACHE;
    assign bus.arprot  = AXI_PROT;
    assign bus.arvalid = (state_q == RADDR);

    assign bus.rready   = (state_q == RDATA) && bus.rd_ready;
    assign bus.rd_valid = (state_q == RDATA) && bus.rvalid;
    assign bus.rd_data  = (state_q == RDATA) ? bus.rdata : '0;
    assign bus.rd_resp  = (state_q == RDATA) ? bus.rresp : '0;
    assign bus.rd_last  = (state_q == RDATA) && (is_last || bus.rlast);

    assign unused_ids = ^{bus.bid, bus.rid};
endmodule
